// File: rtl/pwm_ctrl.sv
// pwm_ctrl: sequencer for the PWM generator datapath.
//
// Owns the prescaler and period counter and keeps double-buffered configuration.
// Register writes land in a shadow copy. The active copy, which drives the generator,
// changes only while idle or when the counter wraps, so a period never sees a
// half-applied configuration.
//
// Ports:
//   clk, rst         clock, asynchronous active-high reset
//   en_in            run request (level); oneshot_in is sampled on IDLE->RUN
//   cfg_wr           strobe capturing period/compare1/compare2/func/prescale into shadow
//   cnt_clr          synchronous counter/prescaler clear (RUN only)
//   pwm_en           high while running
//   period, functions, compare1, compare2   active configuration
//   count_val        current counter value
//   period_done      one-clock pulse on counter wrap
//   update_pending   shadow holds configuration not yet applied
//   done             one-shot period finished
module pwm_ctrl #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PRE_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_in,
    input  logic             oneshot_in,
    input  logic             cfg_wr,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] compare1_in,
    input  logic [CNT_W-1:0] compare2_in,
    input  logic [1:0]       func_in,
    input  logic [PRE_W-1:0] prescale_in,
    input  logic             cnt_clr,
    output logic             pwm_en,
    output logic [CNT_W-1:0] period,
    output logic [1:0]       functions,
    output logic [CNT_W-1:0] compare1,
    output logic [CNT_W-1:0] compare2,
    output logic [CNT_W-1:0] count_val,
    output logic             period_done,
    output logic             update_pending,
    output logic             done
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] cmp1;
        logic [CNT_W-1:0] cmp2;
        logic [1:0]       func;
        logic [PRE_W-1:0] pre;
    } cfg_t;

    state_e           state_q, state_d;
    cfg_t             shadow_q, shadow_d;
    cfg_t             active_q, active_d;
    logic             pending_q, pending_d;
    logic             oneshot_q, oneshot_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pwm_en_q, pwm_en_d;
    logic             period_done_q, period_done_d;
    logic             done_q, done_d;

    cfg_t cfg_in;
    logic tick;

    assign cfg_in = '{
        period: period_in,
        cmp1:   compare1_in,
        cmp2:   compare2_in,
        func:   func_in,
        pre:    prescale_in
    };
    assign tick = (pre_q == active_q.pre);

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        pending_d     = pending_q | cfg_wr;
        oneshot_d     = oneshot_q;
        pre_d         = pre_q;
        count_d       = count_q;
        period_done_d = 1'b0;

        if (cfg_wr) begin
            shadow_d = cfg_in;
        end

        unique case (state_q)
            StIdle: begin
                count_d = '0;
                pre_d   = '0;
                if (cfg_wr && en_in) begin
                    // Bypass the shadow so the very first period uses the new values.
                    active_d  = cfg_in;
                    pending_d = 1'b0;
                end else begin
                    if (pending_q) begin
                        active_d = shadow_q;
                    end
                    // A write this cycle is applied on the next idle cycle.
                    pending_d = cfg_wr;
                end
                if (en_in) begin
                    state_d   = StRun;
                    oneshot_d = oneshot_in;
                end
            end
            StRun: begin
                if (!en_in) begin
                    state_d = StIdle;
                    count_d = '0;
                    pre_d   = '0;
                end else if (cnt_clr) begin
                    // Clear wins over a coincident tick: no wrap, no apply.
                    count_d = '0;
                    pre_d   = '0;
                end else if (tick) begin
                    pre_d = '0;
                    if (count_q == active_q.period) begin
                        count_d       = '0;
                        period_done_d = 1'b1;
                        if (pending_q) begin
                            active_d = shadow_q;
                        end
                        // A write on the wrap cycle waits for the following wrap.
                        pending_d = cfg_wr;
                        if (oneshot_q) begin
                            state_d = StDone;
                        end
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            StDone: begin
                count_d = '0;
                pre_d   = '0;
                if (!en_in) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        pwm_en_d = (state_d == StRun);
        done_d   = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            shadow_q      <= '0;
            active_q      <= '0;
            pending_q     <= 1'b0;
            oneshot_q     <= 1'b0;
            pre_q         <= '0;
            count_q       <= '0;
            pwm_en_q      <= 1'b0;
            period_done_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            pending_q     <= pending_d;
            oneshot_q     <= oneshot_d;
            pre_q         <= pre_d;
            count_q       <= count_d;
            pwm_en_q      <= pwm_en_d;
            period_done_q <= period_done_d;
            done_q        <= done_d;
        end
    end

    assign pwm_en         = pwm_en_q;
    assign period         = active_q.period;
    assign functions      = active_q.func;
    assign compare1       = active_q.cmp1;
    assign compare2       = active_q.cmp2;
    assign count_val      = count_q;
    assign period_done    = period_done_q;
    assign update_pending = pending_q;
    assign done           = done_q;

endmodule

// File: tb/tb_pwm_ctrl.sv
// Self-checking bench for pwm_ctrl: directed scenarios followed by a randomized run,
// every output compared each cycle against a behavioural model of the sequencer.
module tb_pwm_ctrl;

    localparam int CW = 16;
    localparam int PW = 8;

    typedef struct packed {
        logic [CW-1:0] period;
        logic [CW-1:0] cmp1;
        logic [CW-1:0] cmp2;
        logic [1:0]    func;
        logic [PW-1:0] pre;
    } mcfg_t;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en_in = 1'b0, oneshot_in = 1'b0, cfg_wr = 1'b0, cnt_clr = 1'b0;
    logic [CW-1:0] period_in = '0, compare1_in = '0, compare2_in = '0;
    logic [1:0]    func_in = '0;
    logic [PW-1:0] prescale_in = '0;
    logic          pwm_en, period_done, update_pending, done;
    logic [CW-1:0] period, compare1, compare2, count_val;
    logic [1:0]    functions;

    int checks = 0;
    int failures = 0;

    // Model state
    int    m_st;
    mcfg_t m_sh, m_act;
    bit    m_pend, m_os, m_pd;
    int    m_cnt, m_pre;

    pwm_ctrl #(.CNT_W(CW), .PRE_W(PW)) dut (
        .clk            (clk),
        .rst            (rst),
        .en_in          (en_in),
        .oneshot_in     (oneshot_in),
        .cfg_wr         (cfg_wr),
        .period_in      (period_in),
        .compare1_in    (compare1_in),
        .compare2_in    (compare2_in),
        .func_in        (func_in),
        .prescale_in    (prescale_in),
        .cnt_clr        (cnt_clr),
        .pwm_en         (pwm_en),
        .period         (period),
        .functions      (functions),
        .compare1       (compare1),
        .compare2       (compare2),
        .count_val      (count_val),
        .period_done    (period_done),
        .update_pending (update_pending),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_sh = '0; m_act = '0; m_pend = 0; m_os = 0; m_pd = 0;
        m_cnt = 0; m_pre = 0;
    endtask

    // One clock of the sequencer's rules, using the inputs currently driven.
    task automatic model_step();
        mcfg_t nin;
        bit    old_pend;
        nin = '{period: period_in, cmp1: compare1_in, cmp2: compare2_in,
                func: func_in, pre: prescale_in};
        old_pend = m_pend;
        m_pd = 0;
        if (m_st == M_IDLE) begin
            m_cnt = 0; m_pre = 0;
            if (cfg_wr && en_in) begin
                m_act = nin; m_sh = nin; m_pend = 0;
            end else begin
                if (old_pend) m_act = m_sh;
                m_pend = cfg_wr;
                if (cfg_wr) m_sh = nin;
            end
            if (en_in) begin m_st = M_RUN; m_os = oneshot_in; end
        end else if (m_st == M_RUN) begin
            if (!en_in) begin
                m_st = M_IDLE; m_cnt = 0; m_pre = 0;
            end else if (cnt_clr) begin
                m_cnt = 0; m_pre = 0;
            end else if (m_pre < int'(m_act.pre)) begin
                m_pre++;
            end else if (m_cnt < int'(m_act.period)) begin
                m_pre = 0; m_cnt++;
            end else begin
                // End of period
                m_pre = 0; m_cnt = 0; m_pd = 1;
                if (old_pend) begin m_act = m_sh; m_pend = 0; end
                if (m_os) m_st = M_DONE;
            end
            if (cfg_wr) begin m_sh = nin; m_pend = 1; end
        end else begin
            m_cnt = 0; m_pre = 0;
            if (cfg_wr) begin m_sh = nin; m_pend = 1; end
            if (!en_in) m_st = M_IDLE;
        end
    endtask

    task automatic check_all();
        chk("pwm_en", 32'(pwm_en), 32'(m_st == M_RUN));
        chk("done", 32'(done), 32'(m_st == M_DONE));
        chk("count_val", 32'(count_val), 32'(m_cnt));
        chk("period_done", 32'(period_done), 32'(m_pd));
        chk("update_pending", 32'(update_pending), 32'(m_pend));
        chk("period", 32'(period), 32'(m_act.period));
        chk("compare1", 32'(compare1), 32'(m_act.cmp1));
        chk("compare2", 32'(compare2), 32'(m_act.cmp2));
        chk("functions", 32'(functions), 32'(m_act.func));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_all();
        cfg_wr = 1'b0;
        cnt_clr = 1'b0;
    endtask

    task automatic write_cfg(input int p, input int c1, input int c2, input int f, input int pr);
        period_in = CW'(p); compare1_in = CW'(c1); compare2_in = CW'(c2);
        func_in = 2'(f); prescale_in = PW'(pr);
        cfg_wr = 1'b1;
        step();
    endtask

    task automatic wait_cnt(input string tag, input int target);
        for (int i = 0; i < 200 && m_cnt != target; i++) step();
        chk(tag, 32'(count_val), 32'(target));
    endtask

    // Steps until the model says the coming edge ends a period.
    task automatic wait_wrap_cycle(input string tag);
        int guard = 0;
        while (!(m_st == M_RUN && m_pre == int'(m_act.pre) && m_cnt == int'(m_act.period))
               && guard < 200) begin
            step();
            guard++;
        end
        chk(tag, 32'(guard < 200), 32'd1);
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (period_done) pulses++;
        end
    endtask

    initial begin
        int n;
        model_reset();
        #12;
        chk("reset_pwm_en", 32'(pwm_en), 32'd0);
        chk("reset_count", 32'(count_val), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Basic run: period 4, no prescale -> wrap every 5 clocks
        write_cfg(4, 1, 2, 1, 0);
        step();
        en_in = 1'b1;
        step();
        count_pulses(15, n);
        chk("basic_pulses", 32'(n), 32'd3);

        // Asynchronous reset mid-run at count 5 with a pending write
        en_in = 1'b0; step();
        write_cfg(9, 3, 4, 2, 0);
        step();
        en_in = 1'b1; step();
        wait_cnt("reach5", 5);
        write_cfg(7, 7, 7, 3, 1);
        rst = 1'b1;
        #1;
        chk("arst_pwm_en", 32'(pwm_en), 32'd0);
        chk("arst_count", 32'(count_val), 32'd0);
        chk("arst_period", 32'(period), 32'd0);
        chk("arst_pending", 32'(update_pending), 32'd0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        en_in = 1'b0;
        step();

        // Prescaler: period 2, prescale 2 -> wrap every 9 clocks
        write_cfg(2, 1, 1, 0, 2);
        step();
        en_in = 1'b1; step();
        count_pulses(27, n);
        chk("presc_pulses", 32'(n), 32'd3);

        // Shadow update mid-period, then a write on the wrap cycle
        en_in = 1'b0; step();
        write_cfg(9, 1, 2, 0, 0);
        step();
        en_in = 1'b1; step();
        wait_cnt("reach2", 2);
        write_cfg(5, 3, 2, 0, 0);
        chk("shadow_hold", 32'(period), 32'd9);
        for (int i = 0; i < 25; i++) step();
        chk("shadow_applied", 32'(period), 32'd5);
        write_cfg(6, 4, 4, 1, 0);
        wait_wrap_cycle("wrapA");
        write_cfg(3, 2, 2, 2, 0);
        chk("wrap_write_period", 32'(period), 32'd6);
        chk("wrap_write_pending", 32'(update_pending), 32'd1);
        wait_wrap_cycle("wrapB");
        step();
        chk("wrap_write_applied", 32'(period), 32'd3);

        // One-shot: period 3
        en_in = 1'b0; step();
        write_cfg(3, 1, 2, 0, 0);
        oneshot_in = 1'b1;
        en_in = 1'b1; step();
        oneshot_in = 1'b0;
        count_pulses(10, n);
        chk("oneshot_pulses", 32'(n), 32'd1);
        chk("oneshot_done", 32'(done), 32'd1);
        en_in = 1'b0; step();
        chk("oneshot_idle", 32'(done), 32'd0);

        // period 0: every tick is a wrap
        write_cfg(0, 0, 0, 0, 1);
        en_in = 1'b1; step();
        count_pulses(8, n);
        chk("p0_pulses", 32'(n), 32'd4);

        // cnt_clr coincident with a tick at count 6
        en_in = 1'b0; step();
        write_cfg(9, 1, 1, 0, 0);
        en_in = 1'b1; step();
        wait_cnt("reach6", 6);
        cnt_clr = 1'b1;
        step();
        chk("clr_count", 32'(count_val), 32'd0);
        chk("clr_no_pd", 32'(period_done), 32'd0);

        // en_in drop at count 3 with a pending write
        wait_cnt("reach1", 1);
        write_cfg(8, 5, 6, 3, 0);
        wait_cnt("reach3", 3);
        en_in = 1'b0; step();
        step();
        chk("drop_applied", 32'(period), 32'd8);
        chk("drop_pending", 32'(update_pending), 32'd0);

        // Randomized operation against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) en_in = ~en_in;
            oneshot_in = ($urandom_range(0, 3) == 0);
            cnt_clr = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 14) == 0) begin
                period_in = CW'($urandom_range(0, 7));
                compare1_in = CW'($urandom);
                compare2_in = CW'($urandom);
                func_in = 2'($urandom);
                prescale_in = PW'($urandom_range(0, 3));
                cfg_wr = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
